// File: rtl/signal_measure_multi_pkg.sv
// meas_pkg: shared definitions for signal_measure_multi.
//   meas_state_e : controller FSM states
//   div_width()  : divider width derived from the counter width
//   DUTY_SCALE   : duty is reported in percent
//   FREQ_W       : width of the saturating frequency result
package meas_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ARM,
        ST_MEAS,
        ST_DIV_F,
        ST_DIV_D,
        ST_DONE
    } meas_state_e;

    localparam int DUTY_SCALE = 100;
    localparam int FREQ_W     = 26;

    // Eight spare bits hold CLK_FREQ*N and hi*100 without overflow.
    function automatic int div_width(input int cnt_w);
        return cnt_w + 8;
    endfunction

endpackage

// File: rtl/meas_divider.sv
// meas_divider: unsigned restoring divider, one quotient bit per cycle.
//   clk, rst_n : clock, synchronous active-low reset
//   start      : load operands (ignored while busy)
//   dividend   : W-bit numerator
//   divisor    : W-bit denominator (0 yields all-ones quotient)
//   busy       : division in progress
//   done       : one-cycle pulse, quotient valid from then on
//   quotient   : W-bit result
module meas_divider #(
    parameter int W = 40
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [W-1:0] dividend,
    input  logic [W-1:0] divisor,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] quotient
);
    localparam int CW = $clog2(W + 1);

    logic [W-1:0]  rem;
    logic [W-1:0]  den;
    logic [CW-1:0] cnt;
    logic [W:0]    rem_sh;
    logic [W:0]    diff;
    logic          ge;

    // Quotient register doubles as the dividend shift register.
    always_comb begin
        rem_sh = {rem, quotient[W-1]};
        diff   = rem_sh - {1'b0, den};
        ge     = (rem_sh >= {1'b0, den});
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rem      <= '0;
            den      <= '0;
            cnt      <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            quotient <= '0;
        end else begin
            done <= 1'b0;
            if (start && !busy) begin
                rem      <= '0;
                den      <= divisor;
                quotient <= dividend;
                cnt      <= CW'(W);
                busy     <= 1'b1;
            end else if (busy) begin
                if (cnt != '0) begin
                    rem      <= ge ? diff[W-1:0] : rem_sh[W-1:0];
                    quotient <= {quotient[W-2:0], ge};
                    cnt      <= cnt - 1'b1;
                end else begin
                    busy <= 1'b0;
                    done <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/signal_measure_multi.sv
// signal_measure_multi: selects one of NUM_CH async inputs and measures
// average frequency and duty over N periods, bounded by a timeout.
//   clk, rst_n        : clock, synchronous active-low reset
//   enable            : start pulse, honoured only when idle
//   ch_sel, periods   : channel and period count, latched at start
//   sig_in            : asynchronous inputs
//   busy, finish      : in progress / one-cycle completion pulse
//   timeout           : measurement aborted (valid with finish)
//   freq, duty        : average Hz (saturating) and high percentage
//   high_time/low_time: total high/low cycles over N periods
module signal_measure_multi
    import meas_pkg::*;
#(
    parameter int CLK_FREQ    = 50_000_000,
    parameter int NUM_CH      = 4,
    parameter int CNT_W       = 32,
    parameter int TIMEOUT_CYC = 50_000_000
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      enable,
    input  logic [$clog2(NUM_CH)-1:0] ch_sel,
    input  logic [7:0]                periods,
    input  logic [NUM_CH-1:0]         sig_in,
    output logic                      busy,
    output logic                      finish,
    output logic                      timeout,
    output logic [FREQ_W-1:0]         freq,
    output logic [7:0]                duty,
    output logic [CNT_W-1:0]          high_time,
    output logic [CNT_W-1:0]          low_time
);
    localparam int DIV_W = div_width(CNT_W);
    localparam int SEL_W = $clog2(NUM_CH);

    meas_state_e       state;
    logic [NUM_CH-1:0] sync1, sync2;
    logic [SEL_W-1:0]  ch_q;
    logic [7:0]        n_q, edge_cnt;
    logic [CNT_W-1:0]  hi_cnt, lo_cnt, tmo_cnt;
    logic              lvl, lvl_prev, rise, tmo_hit, tmo_q;
    logic [FREQ_W-1:0] freq_q;
    logic [7:0]        duty_q;
    logic              div_start, div_busy, div_done;
    logic [DIV_W-1:0]  div_dividend, div_divisor, div_quo;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= sig_in;
            sync2 <= sync1;
        end
    end

    assign lvl     = sync2[ch_q];
    assign rise    = lvl & ~lvl_prev;
    assign tmo_hit = (tmo_cnt >= CNT_W'(TIMEOUT_CYC - 1));

    always_comb begin
        div_dividend = DIV_W'(hi_cnt) * DIV_W'(DUTY_SCALE);
        if (state == ST_DIV_F)
            div_dividend = DIV_W'(CLK_FREQ) * DIV_W'(n_q);
        div_divisor = DIV_W'(hi_cnt) + DIV_W'(lo_cnt);
    end

    meas_divider #(.W(DIV_W)) u_div (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (div_start & ~div_busy),
        .dividend (div_dividend),
        .divisor  (div_divisor),
        .busy     (div_busy),
        .done     (div_done),
        .quotient (div_quo)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            ch_q      <= '0;
            n_q       <= 8'd1;
            edge_cnt  <= '0;
            hi_cnt    <= '0;
            lo_cnt    <= '0;
            tmo_cnt   <= '0;
            tmo_q     <= 1'b0;
            lvl_prev  <= 1'b0;
            freq_q    <= '0;
            duty_q    <= '0;
            div_start <= 1'b0;
            busy      <= 1'b0;
            finish    <= 1'b0;
            timeout   <= 1'b0;
            freq      <= '0;
            duty      <= '0;
            high_time <= '0;
            low_time  <= '0;
        end else begin
            finish    <= 1'b0;
            div_start <= 1'b0;
            // While idle track the channel about to be latched so the first
            // ARM cycle compares against the same channel's history.
            lvl_prev  <= (state == ST_IDLE) ? sync2[ch_sel] : lvl;
            case (state)
                ST_IDLE: if (enable) begin
                    ch_q     <= ch_sel;
                    n_q      <= (periods == 8'd0) ? 8'd1 : periods;
                    edge_cnt <= '0;
                    hi_cnt   <= '0;
                    lo_cnt   <= '0;
                    tmo_cnt  <= '0;
                    tmo_q    <= 1'b0;
                    busy     <= 1'b1;
                    state    <= ST_ARM;
                end
                ST_ARM: begin
                    tmo_cnt <= tmo_cnt + 1'b1;
                    if (tmo_hit) begin
                        tmo_q <= 1'b1;
                        state <= ST_DONE;
                    end else if (rise) begin
                        state <= ST_MEAS;
                    end
                end
                ST_MEAS: begin
                    // The closing edge cycle is counted as high; it stands in
                    // for the uncounted arming edge cycle, keeping totals exact.
                    tmo_cnt <= tmo_cnt + 1'b1;
                    if (lvl) hi_cnt <= hi_cnt + 1'b1;
                    else     lo_cnt <= lo_cnt + 1'b1;
                    if (rise) edge_cnt <= edge_cnt + 1'b1;
                    if (rise && edge_cnt == n_q - 8'd1) begin
                        div_start <= 1'b1;
                        state     <= ST_DIV_F;
                    end else if (tmo_hit) begin
                        tmo_q <= 1'b1;
                        state <= ST_DONE;
                    end
                end
                ST_DIV_F: if (div_done) begin
                    freq_q    <= (|div_quo[DIV_W-1:FREQ_W]) ? {FREQ_W{1'b1}}
                                                            : div_quo[FREQ_W-1:0];
                    div_start <= 1'b1;
                    state     <= ST_DIV_D;
                end
                ST_DIV_D: if (div_done) begin
                    duty_q <= div_quo[7:0];
                    state  <= ST_DONE;
                end
                ST_DONE: begin
                    finish    <= 1'b1;
                    busy      <= 1'b0;
                    timeout   <= tmo_q;
                    freq      <= tmo_q ? '0 : freq_q;
                    duty      <= tmo_q ? '0 : duty_q;
                    high_time <= tmo_q ? '0 : hi_cnt;
                    low_time  <= tmo_q ? '0 : lo_cnt;
                    state     <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_signal_measure_multi.sv
module tb_signal_measure_multi;
    localparam int CLK   = 50_000_000;
    localparam int NCH   = 4;
    localparam int CW    = 32;
    localparam int TMO   = 10000;
    localparam int SEL_W = 2;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             enable = 1'b0;
    logic [SEL_W-1:0] ch_sel = '0;
    logic [7:0]       periods = '0;
    logic [NCH-1:0]   sig_in;
    logic             busy, finish, timeout;
    logic [25:0]      freq;
    logic [7:0]       duty;
    logic [CW-1:0]    high_time, low_time;

    signal_measure_multi #(
        .CLK_FREQ(CLK), .NUM_CH(NCH), .CNT_W(CW), .TIMEOUT_CYC(TMO)
    ) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .ch_sel(ch_sel),
        .periods(periods), .sig_in(sig_in), .busy(busy), .finish(finish),
        .timeout(timeout), .freq(freq), .duty(duty),
        .high_time(high_time), .low_time(low_time)
    );

    always #10 clk = ~clk;

    typedef struct {
        bit     tmo;
        longint freq, duty, hi, lo;
        int     st;
    } exp_t;

    exp_t sb[$];
    int   vectors = 0;
    int   miscompares = 0;
    int   cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Waveform generator: each channel is a periodic square wave of
    // wh cycles high then wl cycles low; wh=0 holds low, wl=0 holds high.
    int wh[NCH], wl[NCH];
    int cfg_id = 0;

    initial begin
        int ph[NCH];
        int seen;
        logic [NCH-1:0] s;
        seen = -1;
        sig_in = '0;
        forever begin
            @(negedge clk);
            if (seen != cfg_id) begin
                seen = cfg_id;
                for (int c = 0; c < NCH; c++) ph[c] = 0;
            end
            for (int c = 0; c < NCH; c++) begin
                if (wh[c] == 0)      s[c] = 1'b0;
                else if (wl[c] == 0) s[c] = 1'b1;
                else begin
                    s[c]  = (ph[c] < wh[c]);
                    ph[c] = (ph[c] + 1) % (wh[c] + wl[c]);
                end
            end
            sig_in = s;
        end
    end

    task automatic chk(input string name, input longint act, input longint req);
        vectors++;
        if (act != req) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    // Reference: a periodic wave of h high / l low cycles measured over n
    // periods gives h*n and l*n; a wave without rising edges times out.
    function automatic exp_t model(input int h, input int l, input int n);
        exp_t e;
        int ne;
        ne = (n == 0) ? 1 : n;
        e.tmo = 0; e.freq = 0; e.duty = 0; e.hi = 0; e.lo = 0; e.st = 0;
        if (h == 0 || l == 0) e.tmo = 1;
        else begin
            e.hi   = longint'(h) * ne;
            e.lo   = longint'(l) * ne;
            e.freq = (longint'(CLK) * ne) / (e.hi + e.lo);
            if (e.freq > 64'd67108863) e.freq = 67108863;
            e.duty = (e.hi * 100) / (e.hi + e.lo);
        end
        return e;
    endfunction

    // Monitor: pops the scoreboard on every finish pulse.
    always @(negedge clk) begin
        if (rst_n && finish) begin
            if (sb.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_finish: got finish=1, expected none (t=%0t)", $time);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("timeout", longint'(timeout), longint'(e.tmo));
                chk("freq", longint'(freq), e.freq);
                chk("duty", longint'(duty), e.duty);
                chk("high_time", longint'(high_time), e.hi);
                chk("low_time", longint'(low_time), e.lo);
                chk("busy_at_finish", longint'(busy), 0);
                if (e.tmo)
                    chk("timeout_latency_in_window",
                        longint'((cyc - e.st >= TMO - 4) && (cyc - e.st <= TMO + 4)), 1);
            end
        end
    end

    task automatic set_wave(input int c, input int h, input int l);
        wh[c] = h;
        wl[c] = l;
    endtask

    task automatic commit_waves();
        cfg_id++;
        repeat (8) @(negedge clk);
    endtask

    task automatic start_meas(input int ch, input int n, input bit push);
        exp_t e;
        @(negedge clk);
        ch_sel  = SEL_W'(ch);
        periods = 8'(n);
        enable  = 1'b1;
        if (push) begin
            e = model(wh[ch], wl[ch], n);
            e.st = cyc;
            sb.push_back(e);
        end
        @(negedge clk);
        enable = 1'b0;
        chk("busy_rise", longint'(busy), 1);
    endtask

    task automatic wait_drain();
        int k;
        k = 0;
        while (sb.size() != 0 && k < 20000) begin
            @(negedge clk);
            k++;
        end
        if (sb.size() != 0) begin
            vectors++;
            miscompares++;
            $display("FAIL wait_finish: got no finish after %0d cycles, expected finish", k);
            sb.delete();
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_busy"}, longint'(busy), 0);
        chk({tag, "_finish"}, longint'(finish), 0);
        chk({tag, "_timeout"}, longint'(timeout), 0);
        chk({tag, "_freq"}, longint'(freq), 0);
        chk({tag, "_duty"}, longint'(duty), 0);
        chk({tag, "_high"}, longint'(high_time), 0);
        chk({tag, "_low"}, longint'(low_time), 0);
    endtask

    initial begin
        for (int c = 0; c < NCH; c++) set_wave(c, 3 + c, 5 + 2 * c);
        repeat (4) @(negedge clk);
        chk_zero("reset");
        rst_n = 1'b1;
        commit_waves();

        // 500 kHz, 40 %, one period on channel 0
        set_wave(0, 40, 60);
        commit_waves();
        start_meas(0, 1, 1'b1);
        wait_drain();

        // 1 MHz, 50 %, eight periods on channel 2 with neighbours toggling
        set_wave(0, 7, 3); set_wave(1, 2, 9); set_wave(2, 25, 25); set_wave(3, 13, 4);
        commit_waves();
        start_meas(2, 8, 1'b1);
        wait_drain();

        // Channel 1 stuck low: timeout with zeroed results
        set_wave(1, 0, 10);
        commit_waves();
        start_meas(1, 4, 1'b1);
        wait_drain();

        // periods=0 acts as one period; 25 MHz square wave
        set_wave(3, 1, 1);
        commit_waves();
        start_meas(3, 0, 1'b1);
        wait_drain();

        // Re-enable and channel change mid-measurement are ignored
        set_wave(0, 3, 7); set_wave(3, 30, 20);
        commit_waves();
        start_meas(3, 4, 1'b1);
        repeat (80) @(negedge clk);
        ch_sel = 2'd0; periods = 8'd1; enable = 1'b1;
        @(negedge clk);
        enable = 1'b0;
        wait_drain();
        repeat (300) @(negedge clk);

        // Reset mid-measurement: outputs cleared next cycle, no finish
        set_wave(1, 50, 50);
        commit_waves();
        start_meas(1, 5, 1'b0);
        repeat (200) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk_zero("midreset");
        rst_n = 1'b1;
        repeat (700) @(negedge clk);
        start_meas(1, 2, 1'b1);
        wait_drain();

        // Randomized channels, rates and period counts
        for (int i = 0; i < 16; i++) begin
            for (int c = 0; c < NCH; c++)
                set_wave(c, int'($urandom_range(1, 40)), int'($urandom_range(1, 40)));
            commit_waves();
            start_meas(int'($urandom_range(0, NCH - 1)), int'($urandom_range(0, 12)), 1'b1);
            wait_drain();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
